// File: rtl/ts_mac_sequencer.sv
// Frame sequencer for the time-shared polyphase RRC MAC array: phase select, aligned accumulator
// control, output-load strobe and overrun flag. Optional TS_OVERRUN_CNT_EN adds overrun_cnt.
module ts_mac_sequencer #(
  parameter int unsigned PHASES   = 4,
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sam_clk_en,
  input  logic                      en,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic                      acc_clr,
  output logic                      acc_en,
  output logic                      y_load,
  output logic                      busy,
  output logic                      overrun
`ifdef TS_OVERRUN_CNT_EN
  ,
  output logic [7:0]                overrun_cnt
`endif
);

  localparam int unsigned PhW = $clog2(PHASES);

  localparam logic [CNT_W-1:0] RunLast   = CNT_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] FrameLast = CNT_W'(PHASES + MULT_LAT - 1);
  localparam logic [PhW-1:0]   PhaseLast = PhW'(PHASES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PhW-1:0]   phase_q, phase_d;
  logic             y_load_q, y_load_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // Product-valid and first-product flags, delayed to line up with the multiplier pipeline
  logic [MULT_LAT:0] val_pipe_q;
  logic [MULT_LAT:0] clr_pipe_q;
  logic              run_d;
  logic              first_d;

  logic start;
  assign start = sam_clk_en & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RunLast) begin
          state_d = (MULT_LAT == 0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == FrameLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = start ? StRun : StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-state is decoded from the next frame state so every output is a flop
  always_comb begin
    phase_d   = '0;
    run_d     = 1'b0;
    first_d   = 1'b0;
    y_load_d  = 1'b0;
    busy_d    = 1'b0;
    overrun_d = 1'b0;
    unique case (state_d)
      StRun: begin
        phase_d = PhW'(cnt_d);
        run_d   = 1'b1;
        first_d = (cnt_d == '0);
        busy_d  = 1'b1;
      end
      StDrain: begin
        phase_d = PhaseLast;
        busy_d  = 1'b1;
      end
      StDone: begin
        y_load_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: ;
    endcase
    if (start && (state_q == StRun || state_q == StDrain)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      phase_q    <= '0;
      y_load_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      val_pipe_q <= '0;
      clr_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      y_load_q      <= y_load_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      val_pipe_q[0] <= run_d;
      clr_pipe_q[0] <= first_d;
      for (int i = 1; i <= MULT_LAT; i++) begin
        val_pipe_q[i] <= val_pipe_q[i-1];
        clr_pipe_q[i] <= clr_pipe_q[i-1];
      end
    end
  end

  assign phase   = phase_q;
  assign acc_en  = val_pipe_q[MULT_LAT];
  assign acc_clr = clr_pipe_q[MULT_LAT];
  assign y_load  = y_load_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

`ifdef TS_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating; cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else if (overrun_d && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: doc/ts_mac_sequencer.md
Name: ts_mac_sequencer

Overview:
Sequencer for the time-shared polyphase RRC filter datapath.
- On each accepted sample strobe it steps the shared multipliers through PHASES coefficient/tap phases.
- It drives accumulator clear/enable, aligned for multiplier pipeline latency, and a one-cycle output-load strobe.
- It flags sample strobes that arrive before the current frame has finished.
- It sits between the sample-rate enable generator and the filter MAC array. It replaces the free-running phase counter inside the filter.

Parameters:
PHASES, 4, multiplier time-share factor; phases per output sample (2..16)
MULT_LAT, 1, register stages between phase select and product valid (0..4)
CNT_W, 5, width of internal frame cycle counter; must hold PHASES+MULT_LAT

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sam_clk_en  input  1  sample-rate strobe; requests one filter frame
en  input  1  sequencer enable; gates frame starts only
phase  output  $clog2(PHASES)  coefficient/tap select for the MAC array
acc_clr  output  1  load (not add) the first product into the accumulator
acc_en  output  1  accumulate current product
y_load  output  1  accumulator result valid; register filter output
busy  output  1  frame in progress
overrun  output  1  one-cycle pulse: sam_clk_en rejected mid-frame

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, phase=0, acc_clr=0, acc_en=0, y_load=0, busy=0, overrun=0, internal counter=0. Reset mid-frame aborts the frame immediately; no y_load is issued.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, DONE.
- Frame start: sam_clk_en & en sampled high at edge T while in IDLE or DONE.
  - Enter RUN; cycle T+1 has phase=0 and busy=1.
- RUN: phase increments by 1 per cycle, from 0 at T+1 to PHASES-1 at T+PHASES. Then go to DRAIN, or to DONE if MULT_LAT=0.
  - During DRAIN, phase holds at PHASES-1.
- Accumulator control is delayed by MULT_LAT:
  - acc_en is high for PHASES cycles, T+1+MULT_LAT through T+PHASES+MULT_LAT.
  - acc_clr is high only in the first acc_en cycle.
- DRAIN lasts MULT_LAT cycles and then goes to DONE.
- DONE lasts one cycle, at T+PHASES+MULT_LAT+1: y_load=1, busy=1. Next state is IDLE, or RUN if a new start is accepted that same cycle.
  - phase returns to 0 at DONE.
- Frame period is PHASES+MULT_LAT+1 cycles. sam_clk_en in the DONE cycle is accepted (back-to-back; the next phase=0 lands in the following cycle, with no gap).
- Overrun: sam_clk_en high while in RUN or DRAIN is ignored, and the current frame continues unchanged. overrun pulses in the next cycle.
  - Does not apply when en is low.
- en low: no new frame starts. An in-flight frame completes normally. sam_clk_en is silently dropped; overrun does not pulse.
- Simultaneous y_load and a new start: both are honoured, so y_load=1 coincides with the accepted-start cycle.

Optional Feature:
TS_OVERRUN_CNT_EN
- Defined: adds output overrun_cnt [7:0]. It increments on each overrun pulse, saturates at 255, and clears on reset only.
- Undefined: the port and counter are absent; overrun pulse behaviour is unchanged.

Test Plan:
All scenarios use PHASES=4, MULT_LAT=1.
- Reset release, then sam_clk_en at cycle 0 -> phase 0,1,2,3 on cycles 1-4; acc_clr on cycle 2; acc_en on cycles 2-5; y_load on cycle 6; busy on cycles 1-6; overrun never asserted.
- sam_clk_en at cycles 0 and 6 -> second frame phase=0 at cycle 7; y_load at 6 and 12; busy continuous from cycle 1 to 12.
- sam_clk_en at cycles 0 and 3 -> overrun=1 at cycle 4 only; the first frame's timing is unchanged; no second frame starts; y_load only at cycle 6.
- reset_n low at cycle 3 of a frame -> all outputs 0 asynchronously; after release with no strobe, y_load is never seen.
- en=0 with sam_clk_en at cycle 0 -> outputs stay idle, no overrun. en dropped at cycle 2 of a running frame -> that frame still ends with y_load at cycle 6.
- TS_OVERRUN_CNT_EN defined, 300 mid-frame strobes -> overrun_cnt saturates at 255 and holds; reset returns it to 0.
